// File: rtl/cnn_mac_pipe.sv
// Pipelined signed multiply-accumulate for conv1: one shifted, narrowed dot-product per
// last-framed stream of (activation, weight) pairs, with a sticky per-frame overflow flag.
module cnn_mac_pipe #(
    parameter int A_W        = 9,
    parameter int B_W        = 14,
    parameter int MUL_STAGES = 2,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 0,
    parameter int SAT        = 1
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [A_W-1:0]   din0,
    input  logic [B_W-1:0]   din1,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             ovf,
    output logic [7:0]       term_cnt
);

    localparam int PW = A_W + B_W;
    localparam int XW = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [XW-1:0]    OUT_MAX = XW'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [XW-1:0]    OUT_MIN = ~OUT_MAX;

    logic signed [PW-1:0]    p_q [MUL_STAGES];
    logic signed [PW-1:0]    p_d [MUL_STAGES];
    logic [MUL_STAGES-1:0]   v_q, v_d, l_q, l_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    fovf_q, fovf_d;
    logic                    sof_q, sof_d;
    logic [OUT_W-1:0]        dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic                    ovf_q, ovf_d;
    logic [7:0]              term_cnt_q, term_cnt_d;

    logic                    advance, tail_fire, tail_last;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] p_ext, base, acc_new, r_sh;
    logic signed [ACC_W:0]   sum_w;
    logic                    acc_of, out_of, frame_ovf_new;
    logic signed [XW-1:0]    r_x, r_sat;
    logic [OUT_W-1:0]        r_out;
    logic [7:0]              cnt_new;

    // A held result blocks everything upstream, so the whole pipe freezes as one.
    assign advance   = !(dout_valid_q && !dout_ready);
    assign in_ready  = advance;
    assign tail_fire = advance && v_q[MUL_STAGES-1];
    assign tail_last = l_q[MUL_STAGES-1];

    // NOTE: always_comb uses blocking assignments with a default for every target first,
    // so no latch can be inferred; the flops below take only non-blocking assignments.
    always_comb begin
        prod = PW'($signed(din0)) * PW'($signed(din1));
        p_d  = p_q;
        v_d  = v_q;
        l_d  = l_q;
        if (advance) begin
            p_d[0] = prod;
            v_d[0] = in_valid;
            l_d[0] = in_valid && in_last;
            for (int i = 1; i < MUL_STAGES; i++) begin
                p_d[i] = p_q[i-1];
                v_d[i] = v_q[i-1];
                l_d[i] = l_q[i-1];
            end
        end
    end

    always_comb begin
        p_ext  = ACC_W'(p_q[MUL_STAGES-1]);
        base   = sof_q ? '0 : acc_q;
        sum_w  = (ACC_W+1)'(base) + (ACC_W+1)'(p_ext);
        acc_of = sum_w[ACC_W] != sum_w[ACC_W-1];
        if (acc_of && SAT != 0)
            acc_new = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            acc_new = sum_w[ACC_W-1:0];
        frame_ovf_new = (!sof_q && fovf_q) || acc_of;
        cnt_new       = sof_q ? 8'd1 : ((cnt_q == 8'hff) ? 8'hff : cnt_q + 8'd1);

        r_sh   = acc_new >>> SHIFT;
        r_x    = XW'(r_sh);
        out_of = (r_x > OUT_MAX) || (r_x < OUT_MIN);
        r_sat  = (r_x > OUT_MAX) ? OUT_MAX : ((r_x < OUT_MIN) ? OUT_MIN : r_x);
        r_out  = (SAT != 0) ? r_sat[OUT_W-1:0] : r_x[OUT_W-1:0];

        acc_d  = acc_q;
        cnt_d  = cnt_q;
        fovf_d = fovf_q;
        sof_d  = sof_q;
        if (tail_fire) begin
            acc_d  = acc_new;
            cnt_d  = cnt_new;
            fovf_d = frame_ovf_new;
            sof_d  = tail_last;
        end

        dout_d       = dout_q;
        ovf_d        = ovf_q;
        term_cnt_d   = term_cnt_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        if (tail_fire && tail_last) begin
            dout_d       = r_out;
            ovf_d        = frame_ovf_new || out_of;
            term_cnt_d   = cnt_new;
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            v_q          <= '0;
            l_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            fovf_q       <= 1'b0;
            sof_q        <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            term_cnt_q   <= '0;
        end else begin
            v_q          <= v_d;
            l_q          <= l_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            fovf_q       <= fovf_d;
            sof_q        <= sof_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ovf_q        <= ovf_d;
            term_cnt_q   <= term_cnt_d;
        end
        // NOTE: product data is left out of reset; the valid tags alone decide whether it is used.
        p_q <= p_d;
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign ovf        = ovf_q;
    assign term_cnt   = term_cnt_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Directed bench for cnn_mac_pipe: five parameterisations share one stimulus stream and
// each vector is checked on the instance whose parameters it targets.
module tb_cnn_mac_pipe;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [8:0]  din0;
    logic [13:0] din1;
    logic        in_valid, in_last, dout_ready;

    logic [4:0]  rdy, dv, ov;
    logic [7:0]  cnt [5];
    logic [15:0] d0, d4;
    logic [31:0] d1;
    logic [23:0] d2, d3;
    longint      dsx [5];

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    // 0: defaults, 1: OUT_W=32, 2: ACC_W/OUT_W=24 saturating, 3: same wrapping, 4: SHIFT=2
    cnn_mac_pipe u_def (.ap_clk(ap_clk), .ap_rst(ap_rst), .din0(din0), .din1(din1),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[0]), .dout(d0),
        .dout_valid(dv[0]), .dout_ready(dout_ready), .ovf(ov[0]), .term_cnt(cnt[0]));
    cnn_mac_pipe #(.OUT_W(32)) u_w32 (.ap_clk(ap_clk), .ap_rst(ap_rst), .din0(din0),
        .din1(din1), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[1]), .dout(d1),
        .dout_valid(dv[1]), .dout_ready(dout_ready), .ovf(ov[1]), .term_cnt(cnt[1]));
    cnn_mac_pipe #(.ACC_W(24), .OUT_W(24), .SAT(1)) u_a24s (.ap_clk(ap_clk), .ap_rst(ap_rst),
        .din0(din0), .din1(din1), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[2]),
        .dout(d2), .dout_valid(dv[2]), .dout_ready(dout_ready), .ovf(ov[2]), .term_cnt(cnt[2]));
    cnn_mac_pipe #(.ACC_W(24), .OUT_W(24), .SAT(0)) u_a24w (.ap_clk(ap_clk), .ap_rst(ap_rst),
        .din0(din0), .din1(din1), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[3]),
        .dout(d3), .dout_valid(dv[3]), .dout_ready(dout_ready), .ovf(ov[3]), .term_cnt(cnt[3]));
    cnn_mac_pipe #(.SHIFT(2)) u_sh2 (.ap_clk(ap_clk), .ap_rst(ap_rst), .din0(din0),
        .din1(din1), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[4]), .dout(d4),
        .dout_valid(dv[4]), .dout_ready(dout_ready), .ovf(ov[4]), .term_cnt(cnt[4]));

    always_comb begin
        dsx[0] = longint'($signed(d0));
        dsx[1] = longint'($signed(d1));
        dsx[2] = longint'($signed(d2));
        dsx[3] = longint'($signed(d3));
        dsx[4] = longint'($signed(d4));
    end

    typedef struct {
        int     n;
        int     a [4];
        int     b [4];
        int     gap;
        int     inst;
        longint exp_dout;
        int     exp_ovf;
        int     exp_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Drives one pair and returns just after the edge that accepted it.
    task automatic send(input int a, input int b, input bit last);
        int t;
        din0     = 9'(a);
        din1     = 14'(b);
        in_valid = 1'b1;
        in_last  = last;
        t = 0;
        while (!rdy[0] && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) timeout_fail("send_ready");
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input int inst, input string name);
        int t;
        t = 0;
        while (!dv[inst] && t < 30) begin
            tick();
            t++;
        end
        if (t >= 30) timeout_fail(name);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        for (int i = 0; i < v.n; i++) begin
            send(v.a[i], v.b[i], i == v.n - 1);
            if (i != v.n - 1) repeat (v.gap) tick();
        end
        lat = 1;
        while (!dv[v.inst] && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_dout"}, dsx[v.inst], v.exp_dout);
        check({tag, "_ovf"}, ov[v.inst], v.exp_ovf);
        check({tag, "_term_cnt"}, cnt[v.inst], v.exp_cnt);
        tick();
        check({tag, "_valid_pulse"}, dv[v.inst], 0);
    endtask

    initial begin
        vecs[0] = '{3, '{3, -5, 7, 0}, '{4, 6, -8, 0}, 0, 0, -74, 0, 3};
        vecs[1] = '{3, '{3, -5, 7, 0}, '{4, 6, -8, 0}, 0, 4, -19, 0, 3};
        vecs[2] = '{1, '{-256, 0, 0, 0}, '{-8192, 0, 0, 0}, 0, 1, 2097152, 0, 1};
        vecs[3] = '{1, '{-256, 0, 0, 0}, '{-8192, 0, 0, 0}, 0, 0, 32767, 1, 1};
        vecs[4] = '{1, '{-256, 0, 0, 0}, '{8191, 0, 0, 0}, 0, 0, -32768, 1, 1};
        vecs[5] = '{4, '{-256, -256, -256, -256}, '{-8192, -8192, -8192, -8192}, 0, 2, 8388607, 1, 4};
        vecs[6] = '{4, '{-256, -256, -256, -256}, '{-8192, -8192, -8192, -8192}, 0, 3, -8388608, 1, 4};
        vecs[7] = '{2, '{10, 3, 0, 0}, '{10, -1, 0, 0}, 0, 4, 24, 0, 2};
        vecs[8] = '{2, '{10, 3, 0, 0}, '{10, -1, 0, 0}, 0, 3, 97, 0, 2};
        vecs[9] = '{2, '{10, 3, 0, 0}, '{10, -1, 0, 0}, 2, 4, 24, 0, 2};

        ap_rst     = 1'b1;
        din0       = '0;
        din1       = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        dout_ready = 1'b1;
        repeat (3) tick();
        check("rst_dout", dsx[0], 0);
        check("rst_valid", dv[0], 0);
        check("rst_ovf", ov[0], 0);
        check("rst_term_cnt", cnt[0], 0);
        ap_rst = 1'b0;
        tick();
        check("rst_in_ready", rdy[0], 1);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
            repeat (2) tick();
        end

        // Backpressure: two 2-term frames and a single-term frame, no gaps, result held 5 cycles.
        dout_ready = 1'b0;
        fork
            begin
                send(1, 1, 0);
                send(1, 1, 1);
                send(2, 2, 0);
                send(2, 2, 1);
                send(3, 3, 1);
            end
            begin
                wait_valid(0, "bp_first_valid");
                for (int i = 0; i < 5; i++) begin
                    check("bp_in_ready_low", rdy[0], 0);
                    check("bp_hold_dout", dsx[0], 2);
                    check("bp_hold_valid", dv[0], 1);
                    tick();
                end
                dout_ready = 1'b1;
                check("bp_r1_dout", dsx[0], 2);
                check("bp_r1_term_cnt", cnt[0], 2);
                tick();
                wait_valid(0, "bp_second_valid");
                check("bp_r2_dout", dsx[0], 8);
                check("bp_r2_term_cnt", cnt[0], 2);
                tick();
                wait_valid(0, "bp_third_valid");
                check("bp_r3_dout", dsx[0], 9);
                check("bp_r3_term_cnt", cnt[0], 1);
            end
        join
        repeat (3) tick();

        // Reset mid-frame with two terms in flight; the partial frame must vanish.
        send(5, 5, 0);
        send(5, 5, 0);
        ap_rst = 1'b1;
        tick();
        check("mid_rst_dout", dsx[0], 0);
        check("mid_rst_valid", dv[0], 0);
        check("mid_rst_ovf", ov[0], 0);
        check("mid_rst_term_cnt", cnt[0], 0);
        tick();
        ap_rst = 1'b0;
        tick();
        check("post_rst_in_ready", rdy[0], 1);
        for (int i = 0; i < 4; i++) begin
            check("post_rst_no_result", dv[0], 0);
            tick();
        end
        begin
            vec_t v;
            v = '{1, '{2, 0, 0, 0}, '{3, 0, 0, 0}, 0, 0, 6, 0, 1};
            run_vec(v, 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
